// File: rtl/addsub_acc_unit_pkg.sv
// Shared encodings for the add/subtract accumulator front-end:
// command opcodes and the output-stage state.
package addsub_acc_unit_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage : addsub_acc_unit_pkg

// File: rtl/addsub_acc_unit_cla.sv
// W-bit carry-lookahead add/subtract datapath: s = a + (b ^ {W{m}}) + m.
// c is the carry-out of the MSB and v the two's-complement overflow.
module addsub_cla #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic [W-1:0] s,
  output logic         c,
  output logic         v
);

  logic [W-1:0] b_eff;
  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   carry;

  assign b_eff = b ^ {W{m}};
  assign p     = a ^ b_eff;
  assign g     = a & b_eff;

  // Carries are written as the recurrence; synthesis flattens it into
  // generate/propagate lookahead terms.
  always_comb begin
    carry[0] = m;
    for (int i = 0; i < W; i++) begin
      carry[i+1] = g[i] | (p[i] & carry[i]);
    end
  end

  assign s = p ^ carry[W-1:0];
  assign c = carry[W];
  assign v = carry[W] ^ carry[W-1];

endmodule : addsub_cla

// File: rtl/addsub_acc_unit.sv
// Accumulator front-end: accepts LOAD/ADD/SUB/CLR commands, runs them through
// addsub_cla, and holds one registered result beat behind a valid/ready port.
module addsub_acc_unit
  import addsub_acc_unit_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_c,
  output logic         out_v,
  output logic         out_z,
  output logic         sticky_v
);

  state_e       state_q, state_d;
  op_e          op;
  logic         fire_in;
  logic [W-1:0] acc_q;
  logic         c_q, v_q, z_q, sticky_q;

  logic [W-1:0] sum;
  logic         sum_c, sum_v;
  logic [W-1:0] acc_d;
  logic         c_d, v_d, sticky_d;

  assign op        = op_e'(in_op);
  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign fire_in   = in_valid && in_ready;

  addsub_cla #(.W(W)) u_cla (
    .a (acc_q),
    .b (in_data),
    .m (op == OP_SUB),
    .s (sum),
    .c (sum_c),
    .v (sum_v)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fire_in) state_d = FULL;
      FULL:    if (out_ready && !in_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    c_d      = 1'b0;
    v_d      = 1'b0;
    sticky_d = sticky_q;
    case (op)
      OP_LOAD: acc_d = in_data;
      OP_ADD, OP_SUB: begin
        acc_d    = sum;
        c_d      = sum_c;
        v_d      = sum_v;
        sticky_d = sticky_q | sum_v;
      end
      OP_CLR: begin
        acc_d    = '0;
        sticky_d = 1'b0;
      end
      default: acc_d = acc_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Result registers load only on a command transfer, so they hold steady
  // while downstream stalls and ignore in_op/in_data when in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b1;
      sticky_q <= 1'b0;
    end else if (fire_in) begin
      acc_q    <= acc_d;
      c_q      <= c_d;
      v_q      <= v_d;
      z_q      <= (acc_d == '0);
      sticky_q <= sticky_d;
    end
  end

  assign out_res  = acc_q;
  assign out_c    = c_q;
  assign out_v    = v_q;
  assign out_z    = z_q;
  assign sticky_v = sticky_q;

endmodule : addsub_acc_unit

// File: tb/tb_addsub_acc_unit.sv
// Scoreboard bench for addsub_acc_unit: directed commands push hand-computed
// results into a queue; a monitor pops and compares on every output transfer.
module tb_addsub_acc_unit;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    logic         sticky;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_c, out_v, out_z, sticky_v;

  int    checks   = 0;
  int    failures = 0;
  beat_t expq[$];

  localparam logic [1:0] LOAD = 2'b00, ADD = 2'b01, SUB = 2'b10, CLR = 2'b11;

  always #5 clk = ~clk;

  addsub_acc_unit #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_c     (out_c),
    .out_v     (out_v),
    .out_z     (out_z),
    .sticky_v  (sticky_v)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a result transfers when out_valid && out_ready at the edge;
  // inputs only change just after posedge, so negedge sees the edge values.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_beat", {28'd0, out_res}, 32'hdead);
      end else begin
        beat_t e;
        e = expq.pop_front();
        check("res",    {28'd0, out_res}, {28'd0, e.res});
        check("c",      {31'd0, out_c},    {31'd0, e.c});
        check("v",      {31'd0, out_v},    {31'd0, e.v});
        check("z",      {31'd0, out_z},    {31'd0, e.z});
        check("sticky", {31'd0, sticky_v}, {31'd0, e.sticky});
      end
    end
  end

  // Issue one command, waiting (bounded) for in_ready; optionally queue its result.
  task automatic send(input logic [1:0] op, input logic [W-1:0] data,
                      input logic [W-1:0] res, input logic c, input logic v,
                      input logic sticky, input bit push);
    beat_t e;
    int    n;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    e.res = res; e.c = c; e.v = v; e.z = (res == '0); e.sticky = sticky;
    if (push) expq.push_back(e);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 2'bxx;
    in_data  = 'x;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_data   = '0;
    out_ready = 1'b1;
    #17 rst_n = 1'b1;

    // Reset state while idle.
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_z",     {31'd0, out_z},     32'd1);
    check("rst_sticky",    {31'd0, sticky_v},  32'd0);
    check("rst_out_res",   {28'd0, out_res},   32'd0);
    @(posedge clk); #1;

    // Streaming at full rate with out_ready held high.
    send(LOAD, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    send(ADD,  4'd5, 4'd8, 1'b0, 1'b1, 1'b1, 1'b1);
    send(SUB,  4'd8, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    send(CLR,  4'd9, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(LOAD, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    send(SUB,  4'd3, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    send(ADD,  4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("drained_idle", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Backpressure: hold LOAD 1 result, stall ADD 1, then drain+accept together.
    out_ready = 1'b0;
    send(LOAD, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1; in_op = ADD; in_data = 4'd1;
    begin
      beat_t e;
      e.res = 4'd2; e.c = 1'b0; e.v = 1'b0; e.z = 1'b0; e.sticky = 1'b0;
      expq.push_back(e);
    end
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready",  {31'd0, in_ready},  32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_out_res",   {28'd0, out_res},   32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("after_drain_valid", {31'd0, out_valid}, 32'd1);
    check("after_drain_res",   {28'd0, out_res},   32'd2);
    check("after_drain_q",     expq.size(),        32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("bp_queue_empty", expq.size(), 32'd0);
    check("bp_idle",        {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset while a result (acc=7) is held.
    out_ready = 1'b0;
    send(LOAD, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_rst_res", {28'd0, out_res}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_res",   {28'd0, out_res},   32'd0);
    check("async_rst_z",     {31'd0, out_z},     32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(ADD, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("final_queue_empty", expq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_addsub_acc_unit
